pkt_sram_writer: RTL

Downstream stage of the per-port packet fifo. Pulls packet words out of the fifo via next_data and writes them into a circular region of the shared packet SRAM. On each completed packet it emits one descriptor (start address, length, priority) to the scheduler. Tracks free SRAM words and drops whole packets when space is short.

---
 rtl/pkt_sram_pkg.sv | 25 ++
 rtl/sram_free_cnt.sv | 39 +++
 rtl/pkt_sram_writer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pkt_sram_pkg.sv
// Shared definitions for the packet SRAM writer: FSM states and the
// width derivations used by the writer and its free-word counter.
package pkt_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DROP,
        ST_DESC
    } wr_state_t;

    function automatic int unsigned prio_width(input int unsigned num_prio);
        return (num_prio > 1) ? $clog2(num_prio) : 1;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a full-length packet count is representable.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/sram_free_cnt.sv
// Free-word counter for the SRAM region: one word consumed per write strobe,
// released words added back, result saturating at the region size.
module sram_free_cnt #(
    parameter int unsigned SRAM_DEPTH = 1024,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LEN_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rel_vld,
    input  logic [LEN_W-1:0]  rel_len,
    output logic [ADDR_W:0]   free_words
);

    localparam int unsigned SUM_W = ((ADDR_W + 1 > LEN_W) ? ADDR_W + 1 : LEN_W) + 1;

    logic [SUM_W-1:0] rel_ext;
    logic [SUM_W-1:0] sum;

    always_comb begin
        rel_ext = '0;
        if (rel_vld) begin
            rel_ext = SUM_W'(rel_len);
        end
        sum = SUM_W'(free_words) + rel_ext - SUM_W'(wr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_words <= (ADDR_W + 1)'(SRAM_DEPTH);
        end else if (sum > SUM_W'(SRAM_DEPTH)) begin
            free_words <= (ADDR_W + 1)'(SRAM_DEPTH);
        end else begin
            free_words <= sum[ADDR_W:0];
        end
    end

endmodule

// File: rtl/pkt_sram_writer.sv
// Drains complete packets from the port fifo into a circular SRAM region and
// hands one descriptor per stored packet to the scheduler.
module pkt_sram_writer
    import pkt_sram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 16,
    parameter  int unsigned NUM_PRIO    = 8,
    parameter  int unsigned SRAM_DEPTH  = 1024,
    parameter  int unsigned MAX_PKT_LEN = 64,
    localparam int unsigned PRIO_W      = prio_width(NUM_PRIO),
    localparam int unsigned ADDR_W      = addr_width(SRAM_DEPTH),
    localparam int unsigned LEN_W       = len_width(MAX_PKT_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_ready,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  next_data,
    output logic                  sram_wr_en,
    output logic [ADDR_W-1:0]     sram_wr_addr,
    output logic [DATA_WIDTH-1:0] sram_wr_data,
    output logic                  desc_vld,
    input  logic                  desc_rdy,
    output logic [ADDR_W-1:0]     desc_addr,
    output logic [LEN_W-1:0]      desc_len,
    output logic [PRIO_W-1:0]     desc_prio,
    output logic                  desc_trunc,
    input  logic                  rel_vld,
    input  logic [LEN_W-1:0]      rel_len,
    output logic                  drop,
    output logic [ADDR_W:0]       free_words
);

    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_PKT_LEN);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(SRAM_DEPTH - 1);
    localparam logic [ADDR_W:0]   FREE_MIN = (ADDR_W + 1)'(MAX_PKT_LEN);

    wr_state_t         state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt, len_cur;
    logic [PRIO_W-1:0] prio_q, prio_nxt;
    logic              trunc_q, trunc_nxt;
    logic              collect;

    sram_free_cnt #(
        .SRAM_DEPTH (SRAM_DEPTH),
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W)
    ) u_free_cnt (
        .clk        (clk),
        .rst        (rst),
        .wr         (sram_wr_en),
        .rel_vld    (rel_vld),
        .rel_len    (rel_len),
        .free_words (free_words)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            prio_q  <= '0;
            trunc_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            addr_q  <= addr_nxt;
            len_q   <= len_nxt;
            prio_q  <= prio_nxt;
            trunc_q <= trunc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        next_data    = 1'b0;
        sram_wr_en   = 1'b0;
        sram_wr_addr = wr_ptr;
        sram_wr_data = '0;
        drop         = 1'b0;
        wr_ptr_nxt   = wr_ptr;
        addr_nxt     = addr_q;
        len_nxt      = len_q;
        len_cur      = len_q;
        prio_nxt     = prio_q;
        trunc_nxt    = trunc_q;
        collect      = 1'b0;

        case (state)
            ST_IDLE: begin
                next_data = fifo_ready;
                if (in_sop) begin
                    if (free_words >= FREE_MIN) begin
                        state_nxt = ST_WRITE;
                        addr_nxt  = wr_ptr;
                        len_cur   = '0;
                        len_nxt   = '0;
                        trunc_nxt = 1'b0;
                        collect   = 1'b1;
                    end else if (in_vld && in_eop) begin
                        drop = 1'b1;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_WRITE: begin
                next_data = 1'b1;
                // A fresh sop closes the open packet; that sop word is not stored.
                if (in_sop) begin
                    trunc_nxt = 1'b1;
                    state_nxt = ST_DESC;
                end else begin
                    collect = 1'b1;
                end
            end
            ST_DROP: begin
                next_data = 1'b1;
                if (in_sop || (in_vld && in_eop)) begin
                    drop      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DESC: begin
                if (desc_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Shared word handling for the sop cycle in IDLE and the body in WRITE.
        if (collect && in_vld) begin
            if (len_cur < LEN_MAX) begin
                sram_wr_en   = 1'b1;
                sram_wr_data = in_data;
                wr_ptr_nxt   = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                len_nxt      = len_cur + 1'b1;
                if (len_cur == '0) begin
                    prio_nxt = in_data[PRIO_W-1:0];
                end
            end else begin
                trunc_nxt = 1'b1;
            end
            if (in_eop) begin
                state_nxt = ST_DESC;
            end
        end
    end

    assign desc_vld   = (state == ST_DESC);
    assign desc_addr  = addr_q;
    assign desc_len   = len_q;
    assign desc_prio  = prio_q;
    assign desc_trunc = trunc_q;

endmodule
